// File: rtl/flow_ctrl_pkg.sv
// Shared constants for the pipeline flow controller: flow codes, FSM state
// codes and a packed bundle holding one flow code per pipeline boundary.
package flow_ctrl_pkg;

    localparam int FLOW_WIDTH     = 2;
    localparam int REG_ADDR_WIDTH = 5;

    // Flow codes understood by every stage register.
    localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'b00;
    localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'b01;
    localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'b10;

    // Controller FSM state codes.
    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_MD_WAIT   = 2'd1;
    localparam logic [1:0] ST_INT_DRAIN = 2'd2;
    localparam logic [1:0] ST_INT_ACK   = 2'd3;

    // One flow code per boundary, ordered PC first, MEM/WB last.
    typedef struct packed {
        logic [FLOW_WIDTH-1:0] pc;
        logic [FLOW_WIDTH-1:0] if_id;
        logic [FLOW_WIDTH-1:0] ex;
        logic [FLOW_WIDTH-1:0] mem;
        logic [FLOW_WIDTH-1:0] wb;
    } flow_vec_t;

    // Named output patterns used by the controller.
    localparam flow_vec_t FV_ALL_WORK  = {FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK};
    localparam flow_vec_t FV_ALL_RESET = {FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH,
                                          FLOW_REFRESH, FLOW_REFRESH};
    localparam flow_vec_t FV_MEM_STALL = {FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_REFRESH};
    localparam flow_vec_t FV_REDIRECT  = {FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};
    localparam flow_vec_t FV_INT_HOLD  = {FLOW_STOP, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};
    localparam flow_vec_t FV_MD_HOLD   = {FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_WORK};
    localparam flow_vec_t FV_LOAD_USE  = {FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};

endpackage

// File: rtl/flow_ctrl_hazard_det.sv
// Load-use detector: flags when the instruction in ID reads a register that
// the load currently in EX has not yet fetched from memory.
module flow_hazard_det
    import flow_ctrl_pkg::*;
(
    input  logic                      reg1_rd_en_i,
    input  logic                      reg2_rd_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg1_rd_adder_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg2_rd_adder_i,
    input  logic                      ex_mem_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_adder_i,
    output logic                      load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    always_comb begin
        rs1_hit    = reg1_rd_en_i && (reg1_rd_adder_i == ex_reg_wr_adder_i);
        rs2_hit    = reg2_rd_en_i && (reg2_rd_adder_i == ex_reg_wr_adder_i);
        load_use_o = ex_mem_rd_i && (ex_reg_wr_adder_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/flow_ctrl.sv
// Pipeline flow controller: arbitrates stalls, flushes, multi-cycle mul/div
// waits and interrupt entry, driving one flow code per pipeline boundary.
module flow_ctrl
    import flow_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_reg1_rd_en_i,
    input  logic                      id_reg2_rd_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_reg1_rd_adder_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_reg2_rd_adder_i,
    input  logic                      ex_mem_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_adder_i,
    input  logic                      jump_flag_i,
    input  logic                      md_start_i,
    input  logic                      md_done_i,
    input  logic                      mem_stall_i,
    input  logic                      int_req_i,
    output logic [FLOW_WIDTH-1:0]     flow_pc_o,
    output logic [FLOW_WIDTH-1:0]     flow_if_id_o,
    output logic [FLOW_WIDTH-1:0]     flow_ex_o,
    output logic [FLOW_WIDTH-1:0]     flow_mem_o,
    output logic [FLOW_WIDTH-1:0]     flow_wb_o,
    output logic                      int_ack_o,
    output logic [CNT_WIDTH-1:0]      bubble_cnt_o
);

    // A zero drain length still needs one drain cycle before the ack.
    localparam int                DRAIN_EFF  = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int                DCNT_W     = $clog2(DRAIN_EFF + 1);
    localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(DRAIN_EFF - 1);

    logic [1:0]           state_q,      state_d;
    logic [DCNT_W-1:0]    drain_cnt_q,  drain_cnt_d;
    logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
    flow_vec_t            flow_fsm;
    flow_vec_t            flow_out;
    logic                 load_use;

    flow_hazard_det u_hazard (
        .reg1_rd_en_i      (id_reg1_rd_en_i),
        .reg2_rd_en_i      (id_reg2_rd_en_i),
        .reg1_rd_adder_i   (id_reg1_rd_adder_i),
        .reg2_rd_adder_i   (id_reg2_rd_adder_i),
        .ex_mem_rd_i       (ex_mem_rd_i),
        .ex_reg_wr_adder_i (ex_reg_wr_adder_i),
        .load_use_o        (load_use)
    );

    // FSM next-state, drain countdown and per-state flow pattern.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        flow_fsm    = FV_ALL_WORK;
        case (state_q)
            ST_RUN: begin
                if (mem_stall_i) begin
                    flow_fsm = FV_MEM_STALL;
                end else if (jump_flag_i) begin
                    // A redirect wins over a pending interrupt; it is taken next cycle.
                    flow_fsm = FV_REDIRECT;
                end else if (int_req_i) begin
                    flow_fsm    = FV_INT_HOLD;
                    drain_cnt_d = DRAIN_INIT;
                    state_d     = ST_INT_DRAIN;
                end else if (md_start_i) begin
                    flow_fsm = FV_MD_HOLD;
                    state_d  = ST_MD_WAIT;
                end else if (load_use) begin
                    flow_fsm = FV_LOAD_USE;
                end
            end
            ST_MD_WAIT: begin
                // Interrupts and redirects wait until the mul/div result retires.
                if (mem_stall_i) begin
                    flow_fsm = FV_MEM_STALL;
                end else if (md_done_i) begin
                    state_d = ST_RUN;
                end else begin
                    flow_fsm = FV_MD_HOLD;
                end
            end
            ST_INT_DRAIN: begin
                // Older instructions keep retiring; a bus stall freezes the countdown.
                if (mem_stall_i) begin
                    flow_fsm = FV_MEM_STALL;
                end else begin
                    flow_fsm = FV_INT_HOLD;
                    if (drain_cnt_q == '0) begin
                        state_d = ST_INT_ACK;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DCNT_W'(1);
                    end
                end
            end
            default: begin
                // ST_INT_ACK: the PC loads the trap vector this cycle.
                flow_fsm = FV_REDIRECT;
                state_d  = ST_RUN;
            end
        endcase
    end

    // Stage registers see REFRESH throughout reset, independent of the clock.
    always_comb begin
        flow_out = rst_n ? flow_fsm : FV_ALL_RESET;
    end

    // Saturating count of cycles where any boundary is not WORK.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((flow_out != FV_ALL_WORK) && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            drain_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign flow_pc_o    = flow_out.pc;
    assign flow_if_id_o = flow_out.if_id;
    assign flow_ex_o    = flow_out.ex;
    assign flow_mem_o   = flow_out.mem;
    assign flow_wb_o    = flow_out.wb;
    assign int_ack_o    = (state_q == ST_INT_ACK);
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_flow_ctrl.sv
// Scoreboard bench for flow_ctrl: a behavioural model queues the expected
// per-cycle response; an independent monitor compares on the falling edge.
module tb_flow_ctrl;

    localparam int CW      = 8;
    localparam int DRAIN   = 2;
    localparam int BUB_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en1 = 0, en2 = 0, ld = 0, jump = 0, mds = 0, mdd = 0, stall = 0, intr = 0;
    logic [4:0]    rs1 = 0, rs2 = 0, rd = 0;
    logic [1:0]    f_pc, f_ifid, f_ex, f_mem, f_wb;
    logic          ack;
    logic [CW-1:0] bub;

    always #5 clk = ~clk;

    flow_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_WIDTH(CW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .id_reg1_rd_en_i    (en1),
        .id_reg2_rd_en_i    (en2),
        .id_reg1_rd_adder_i (rs1),
        .id_reg2_rd_adder_i (rs2),
        .ex_mem_rd_i        (ld),
        .ex_reg_wr_adder_i  (rd),
        .jump_flag_i        (jump),
        .md_start_i         (mds),
        .md_done_i          (mdd),
        .mem_stall_i        (stall),
        .int_req_i          (intr),
        .flow_pc_o          (f_pc),
        .flow_if_id_o       (f_ifid),
        .flow_ex_o          (f_ex),
        .flow_mem_o         (f_mem),
        .flow_wb_o          (f_wb),
        .int_ack_o          (ack),
        .bubble_cnt_o       (bub)
    );

    typedef struct {
        bit       rst_n, stall, jump, intr, mds, mdd, ld, en1, en2;
        bit [4:0] rs1, rs2, rd;
    } stim_t;

    typedef struct {
        string flows;
        bit    ack;
        int    bub;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Model state: pending mul/div, drain cycles left, ack due next cycle, bubble count.
    bit   m_md   = 0;
    int   m_drain = 0;
    bit   m_ack  = 0;
    int   m_bub  = 0;

    function automatic string fchar(logic [1:0] f);
        case (f)
            2'b00:   return "W";
            2'b01:   return "S";
            2'b10:   return "R";
            default: return "X";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic check_s(input string name, input string act, input string exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %s expected %s at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n: 1, default: 0};
        return s;
    endfunction

    // Drive one cycle of stimulus and queue the response the spec demands.
    task automatic cyc(input stim_t s);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; stall = s.stall; jump = s.jump; intr = s.intr;
        mds = s.mds; mdd = s.mdd; ld = s.ld; en1 = s.en1; en2 = s.en2;
        rs1 = s.rs1; rs2 = s.rs2; rd = s.rd;
        if (!s.rst_n) begin
            e = '{"RRRRR", 0, 0};
            m_md = 0; m_drain = 0; m_ack = 0; m_bub = 0;
        end else begin
            e.ack = m_ack;
            e.bub = m_bub;
            if (m_ack) begin
                e.flows = "WRRWW";
                m_ack = 0;
            end else if (m_drain > 0) begin
                if (s.stall) e.flows = "SSSSR";
                else begin
                    e.flows = "SRRWW";
                    m_drain--;
                    if (m_drain == 0) m_ack = 1;
                end
            end else if (m_md) begin
                if (s.stall) e.flows = "SSSSR";
                else if (s.mdd) begin e.flows = "WWWWW"; m_md = 0; end
                else e.flows = "SSSRW";
            end else begin
                lu = s.ld && (s.rd != 0) &&
                     ((s.en1 && s.rs1 == s.rd) || (s.en2 && s.rs2 == s.rd));
                if (s.stall) e.flows = "SSSSR";
                else if (s.jump) e.flows = "WRRWW";
                else if (s.intr) begin e.flows = "SRRWW"; m_drain = (DRAIN < 1) ? 1 : DRAIN; end
                else if (s.mds) begin e.flows = "SSSRW"; m_md = 1; end
                else if (lu) e.flows = "SSRWW";
                else e.flows = "WWWWW";
            end
            if (e.flows != "WWWWW" && m_bub < BUB_MAX) m_bub++;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compares every presented cycle against the head of the scoreboard.
    initial begin
        exp_t  e;
        string got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {fchar(f_pc), fchar(f_ifid), fchar(f_ex), fchar(f_mem), fchar(f_wb)};
                check_s("flows", got, e.flows);
                check("int_ack", int'(ack), int'(e.ack));
                check("bubble_cnt", int'(bub), e.bub);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        // Reset
        s = idle(); s.rst_n = 0;
        repeat (2) cyc(s);
        cyc(idle());
        // T1: load-use on rs1 = x5, then rs2, then rd = x0 (no stall)
        s = idle(); s.ld = 1; s.rd = 5; s.en1 = 1; s.rs1 = 5; cyc(s);
        cyc(idle());
        s = idle(); s.ld = 1; s.rd = 7; s.en2 = 1; s.rs2 = 7; s.en1 = 1; s.rs1 = 3; cyc(s);
        s = idle(); s.ld = 1; s.rd = 0; s.en1 = 1; s.rs1 = 0; cyc(s);
        s = idle(); s.ld = 1; s.rd = 4; s.en1 = 0; s.rs1 = 4; cyc(s);
        // T2: jump with interrupt pending, interrupt held until ack
        s = idle(); s.jump = 1; s.intr = 1; cyc(s);
        s = idle(); s.intr = 1; repeat (4) cyc(s);
        repeat (2) cyc(idle());
        // T3: mul/div with interrupt raised mid-wait
        s = idle(); s.mds = 1; cyc(s);
        for (int i = 0; i < 32; i++) begin
            s = idle(); s.intr = (i >= 10); s.jump = (i == 5); cyc(s);
        end
        s = idle(); s.mdd = 1; s.intr = 1; cyc(s);
        s = idle(); s.intr = 1; repeat (4) cyc(s);
        cyc(idle());
        // T4: bus stall during drain; interrupt dropped mid-drain
        s = idle(); s.intr = 1; cyc(s);
        s = idle(); s.stall = 1; repeat (3) cyc(s);
        repeat (4) cyc(idle());
        // T5: reset asserted mid mul/div wait
        s = idle(); s.mds = 1; cyc(s);
        repeat (5) cyc(idle());
        s = idle(); s.rst_n = 0; repeat (2) cyc(s);
        repeat (3) cyc(idle());
        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(199, 0) != 0);
            s.stall = ($urandom_range(99, 0) < 10);
            s.jump  = ($urandom_range(99, 0) < 10);
            s.intr  = ($urandom_range(99, 0) < 6);
            s.mds   = ($urandom_range(99, 0) < 8);
            s.mdd   = ($urandom_range(99, 0) < 20);
            s.ld    = ($urandom_range(99, 0) < 40);
            s.en1   = $urandom_range(1, 0);
            s.en2   = $urandom_range(1, 0);
            s.rs1   = 5'($urandom_range(7, 0));
            s.rs2   = 5'($urandom_range(7, 0));
            s.rd    = 5'($urandom_range(7, 0));
            cyc(s);
        end
        // T6: saturation of the bubble counter
        s = idle(); s.rst_n = 0; cyc(s);
        s = idle(); s.stall = 1; repeat (BUB_MAX + 4) cyc(s);
        repeat (2) cyc(idle());
        // Let the monitor drain the scoreboard
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
